// File: rtl/sram_ctrl.sv
// SRAM initiator: converts single-beat valid/ready requests into phased
// asynchronous-SRAM write and read cycles with programmable phase widths.
module sram_ctrl #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int WR_SETUP  = 1,
  parameter int WR_PULSE  = 1,
  parameter int WR_HOLD   = 1,
  parameter int RD_SETUP  = 1,
  parameter int RD_ACCESS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          sram_cs,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  output logic          sram_wr,
  output logic          sram_rd,
  input  logic [DW-1:0] sram_dout
);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_SETUP,
    R_ACCESS
  } state_e;

  // Each phase counter loads N-1 on entry; the phase ends on the edge where it reads 0.
  localparam logic [3:0] WS_LOAD = 4'(WR_SETUP - 1);
  localparam logic [3:0] WP_LOAD = 4'(WR_PULSE - 1);
  localparam logic [3:0] WH_LOAD = 4'(WR_HOLD - 1);
  localparam logic [3:0] RS_LOAD = 4'(RD_SETUP - 1);
  localparam logic [3:0] RA_LOAD = 4'(RD_ACCESS - 1);

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            ready_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rdata_q;
  logic            cs_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   din_q;
  logic            wr_q;
  logic            rd_q;
  logic            last_phase;

  assign last_phase = (cnt_q == 4'd0);

  // NOTE: every output is a flop assigned with <= so no input reaches an output
  // combinationally, and the async reset drops wr / raises rd without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q != IDLE && !last_phase) cnt_q <= cnt_q - 4'd1;

      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            ready_q <= 1'b0;
            cs_q    <= 1'b1;
            addr_q  <= req_addr;
            if (req_we) begin
              state_q <= W_SETUP;
              cnt_q   <= WS_LOAD;
              din_q   <= req_wdata;
            end else begin
              state_q <= R_SETUP;
              cnt_q   <= RS_LOAD;
              din_q   <= '0;
            end
          end
        end
        W_SETUP: begin
          if (last_phase) begin
            state_q <= W_PULSE;
            cnt_q   <= WP_LOAD;
            wr_q    <= 1'b1;
          end
        end
        W_PULSE: begin
          if (last_phase) begin
            state_q <= W_HOLD;
            cnt_q   <= WH_LOAD;
            wr_q    <= 1'b0;
          end
        end
        W_HOLD: begin
          if (last_phase) begin
            state_q <= IDLE;
            cs_q    <= 1'b0;
            din_q   <= '0;
            ready_q <= 1'b1;
          end
        end
        R_SETUP: begin
          if (last_phase) begin
            state_q <= R_ACCESS;
            cnt_q   <= RA_LOAD;
            rd_q    <= 1'b0;
          end
        end
        R_ACCESS: begin
          if (last_phase) begin
            state_q     <= IDLE;
            rdata_q     <= sram_dout;
            rd_q        <= 1'b1;
            cs_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            ready_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign sram_cs   = cs_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign sram_wr   = wr_q;
  assign sram_rd   = rd_q;

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Synchronous initiator that drives the asynchronous SRAM port: cs, addr, din, wr and rd, and samples dout.
- Converts a single-beat valid/ready request interface into correctly phased SRAM write and read cycles with programmable setup, pulse, hold and access widths.
- Sits between the system datapath and the SRAM macro.
- Owns all SRAM strobe timing so upstream logic never touches the strobes directly.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- WR_SETUP, 1, cycles that addr/din are valid before wr rises (1..15).
- WR_PULSE, 1, cycles wr is held high (1..15).
- WR_HOLD, 1, cycles din/addr are held after wr falls (1..15).
- RD_SETUP, 1, cycles addr is valid before rd falls (1..15).
- RD_ACCESS, 2, cycles rd is held low; dout is sampled on the last of these cycles (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  request address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle pulse: rsp_rdata holds read data.
- rsp_rdata  out  DW  read data.
- sram_cs  out  1  chip select, active high.
- sram_addr  out  AW  SRAM address.
- sram_din  out  DW  SRAM write data.
- sram_wr  out  1  write strobe, active high.
- sram_rd  out  1  read strobe, active low.
- sram_dout  in  DW  SRAM read data.

Behaviour:
- **Reset values:** req_ready=1, rsp_valid=0, rsp_rdata=0, sram_cs=0, sram_addr=0, sram_din=0, sram_wr=0, sram_rd=1, FSM=IDLE, counter=0.
- **Registered outputs:** all outputs are registered, so there are no combinational paths from inputs to outputs.
- **Handshake:**
  - A request is accepted on a rising edge where req_valid and req_ready are both 1.
  - req_we, req_addr and req_wdata are captured at that edge.
  - req_ready=0 from the cycle after acceptance until the FSM returns to IDLE.
  - Requests presented while req_ready=0 are ignored; no queueing.
- **FSM states:** IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_ACCESS. A 4-bit phase counter loads N-1 on state entry and the state exits when it reaches 0.
- **IDLE:**
  - cs=0, wr=0, rd=1, din=0; sram_addr keeps its last value.
  - On accept, go to W_SETUP if req_we=1, otherwise R_SETUP.
- **W_SETUP (WR_SETUP cycles):** cs=1, addr=captured address, din=captured data, wr=0. Then go to W_PULSE.
- **W_PULSE (WR_PULSE cycles):** wr=1; addr and din unchanged. Then go to W_HOLD.
- **W_HOLD (WR_HOLD cycles):** wr=0; cs, addr and din unchanged. Then go to IDLE. Writes produce no rsp_valid.
- **R_SETUP (RD_SETUP cycles):** cs=1, addr driven, rd=1, din=0. Then go to R_ACCESS.
- **R_ACCESS (RD_ACCESS cycles):**
  - rd=0.
  - On the edge that ends the last access cycle: rsp_rdata<=sram_dout, rd<=1, cs<=0, rsp_valid<=1, and the FSM goes to IDLE.
  - rsp_valid is high for exactly one cycle, concurrent with the first IDLE cycle in which req_ready=1.
  - rsp_rdata holds its value until the next read completes.
- **Exclusivity:** wr and rd-low are never active in the same cycle. wr is never 1 while cs=0.
- **Latency with defaults (acceptance edge = E0):**
  - Write: wr high during E1..E2; req_ready=1 after E3.
  - Read: rd low during E1..E3; rsp_valid=1 after E3.
- **Back-to-back:** a request held valid is accepted on the first IDLE edge, so there is exactly one IDLE cycle with cs=0 between transactions (turnaround).
- **Reset mid-operation:**
  - Asynchronous return to the reset values; wr drops and rd rises immediately.
  - The in-flight transaction is discarded and no rsp_valid is produced.
  - Normal operation resumes on the first edge after rst_n rises.

Test Plan:
1. **Write:** reset, then write addr=0xCA, data=0xB5 → cs=1 for 3 cycles; din=0xB5 for all 3; wr=1 only in the middle cycle; req_ready=1 after E3; no rsp_valid.
2. **Read-back:** SRAM model, read 0xCA → rd=0 for 2 cycles with addr=0xCA; rsp_valid pulses once; rsp_rdata=0xB5 and holds afterwards.
3. **Back-to-back:** write 0x10←0x5A then read 0x10 with req_valid held high → second request accepted after exactly one cs=0 cycle; rsp_rdata=0x5A; wr and rd never active together.
4. **Busy:** assert a request during W_PULSE → it is ignored while req_ready=0 and accepted only on the IDLE edge; the captured address is the one presented at the accepting edge.
5. **Reset mid-write:** drop rst_n during W_PULSE → wr=0, cs=0, rd=1 immediately; no SRAM write completes; after release, a read of 0xCA returns the prior contents.
6. **Timing override:** WR_SETUP=2, WR_PULSE=3, WR_HOLD=2, RD_ACCESS=4 → wr high exactly 3 cycles; rd low exactly 4 cycles; rsp_valid follows on the next cycle.
